// File: rtl/scoreboard_hazard_if.sv
// -----------------------------------------------------------------------------
// scoreboard_hazard_if
// Decode-stage hazard interface between the pipeline control (master) and the
// hazard scoreboard (slave).
//   flush        : pipeline flush, drops every tracked producer
//   stall_hold   : external ID/EX freeze
//   id_valid     : decode instruction valid
//   rs_raddr/rs_re, rt_raddr/rt_re : source registers and read enables
//   id_we/id_waddr : destination write enable / GPR
//   id_lat       : result class (00 ALU, 01 load, 10 mul/div, 11 load)
//   div_done     : long-op unit writes back this cycle
//   stall_req    : decode must hold
//   stall_reason : 00 none, 01 load-use, 10 long-op data/WAW, 11 long-op structural
//   stall_cnt    : saturating count of stalled decode cycles
// -----------------------------------------------------------------------------
interface scoreboard_hazard_if;
   logic        flush;
   logic        stall_hold;
   logic        id_valid;
   logic [4:0]  rs_raddr;
   logic [4:0]  rt_raddr;
   logic        rs_re;
   logic        rt_re;
   logic        id_we;
   logic [4:0]  id_waddr;
   logic [1:0]  id_lat;
   logic        div_done;
   logic        stall_req;
   logic [1:0]  stall_reason;
   logic [15:0] stall_cnt;

   modport master (
      output flush, stall_hold, id_valid, rs_raddr, rt_raddr, rs_re, rt_re,
             id_we, id_waddr, id_lat, div_done,
      input  stall_req, stall_reason, stall_cnt
   );

   modport slave (
      input  flush, stall_hold, id_valid, rs_raddr, rt_raddr, rs_re, rt_re,
             id_we, id_waddr, id_lat, div_done,
      output stall_req, stall_reason, stall_cnt
   );
endinterface

// File: rtl/scoreboard_hazard.sv
// -----------------------------------------------------------------------------
// scoreboard_hazard
// Decode-stage register scoreboard. Tracks per-GPR load-use countdowns and a
// single outstanding long (mul/div) operation, and requests a decode stall when
// the instruction in decode would read or overwrite a result that is not yet
// available, or would need the busy long-op unit.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   sb     : scoreboard_hazard_if.slave (decode request, flush/hold, stall out)
// -----------------------------------------------------------------------------
module scoreboard_hazard (
   input  logic               clk,
   input  logic               resetn,
   scoreboard_hazard_if.slave sb
);

   localparam logic [1:0] LAT_ALU      = 2'b00;
   localparam logic [1:0] LAT_LOAD     = 2'b01;
   localparam logic [1:0] LAT_LONG     = 2'b10;
   localparam logic [1:0] LAT_LOAD_ALT = 2'b11;

   localparam logic [1:0] RSN_NONE   = 2'b00;
   localparam logic [1:0] RSN_LOAD   = 2'b01;
   localparam logic [1:0] RSN_DATA   = 2'b10;
   localparam logic [1:0] RSN_STRUCT = 2'b11;

   // per-GPR cycles until a load result can be forwarded; entry 0 stays zero
   logic [1:0]  pend_q [32];
   logic [1:0]  pend_d [32];
   logic        long_busy_q,  long_busy_d;
   logic [4:0]  long_waddr_q, long_waddr_d;
   logic [15:0] stall_cnt_q,  stall_cnt_d;

   logic        long_active;
   logic        lu_haz;
   logic        ld_haz;
   logic        st_haz;
   logic        stall_req;
   logic [1:0]  stall_reason;
   logic        issue;
   logic        is_load;
   logic        is_alu;
   logic        is_long;
   logic        wr_pend;

   always_comb begin
      is_load = (sb.id_lat == LAT_LOAD) || (sb.id_lat == LAT_LOAD_ALT);
      is_alu  = (sb.id_lat == LAT_ALU);
      is_long = (sb.id_lat == LAT_LONG);

      // write-back this cycle already reaches the bypass, so it no longer blocks
      long_active = long_busy_q && !sb.div_done;

      lu_haz = (sb.rs_re && (sb.rs_raddr != 5'd0) && (pend_q[sb.rs_raddr] != 2'd0)) ||
               (sb.rt_re && (sb.rt_raddr != 5'd0) && (pend_q[sb.rt_raddr] != 2'd0));

      ld_haz = long_active && (long_waddr_q != 5'd0) &&
               ((sb.rs_re && (sb.rs_raddr == long_waddr_q)) ||
                (sb.rt_re && (sb.rt_raddr == long_waddr_q)) ||
                (sb.id_we && (sb.id_waddr == long_waddr_q)));

      st_haz = long_active && is_long;

      stall_req    = sb.id_valid && (lu_haz || ld_haz || st_haz);
      stall_reason = RSN_NONE;
      if (sb.id_valid) begin
         if (lu_haz)      stall_reason = RSN_LOAD;
         else if (ld_haz) stall_reason = RSN_DATA;
         else if (st_haz) stall_reason = RSN_STRUCT;
      end

      issue   = sb.id_valid && !stall_req && !sb.stall_hold && !sb.flush;
      wr_pend = issue && sb.id_we && (sb.id_waddr != 5'd0) && (is_load || is_alu);
   end

   always_comb begin
      for (int unsigned i = 0; i < 32; i++) begin
         pend_d[i] = pend_q[i];
         if (i == 0) begin
            pend_d[i] = '0;
         end else if (sb.flush) begin
            pend_d[i] = '0;
         end else if (wr_pend && (sb.id_waddr == 5'(i))) begin
            // an ALU write supersedes an older load to the same register
            pend_d[i] = is_load ? 2'd2 : 2'd0;
         end else if (!sb.stall_hold && (pend_q[i] != 2'd0)) begin
            pend_d[i] = pend_q[i] - 2'd1;
         end
      end

      long_busy_d  = long_busy_q;
      long_waddr_d = long_waddr_q;
      if (sb.flush) begin
         long_busy_d = 1'b0;
      end else if (issue && is_long) begin
         // a new long op issued in its predecessor's done cycle keeps the unit busy
         long_busy_d  = 1'b1;
         long_waddr_d = sb.id_waddr;
      end else if (sb.div_done) begin
         long_busy_d = 1'b0;
      end

      stall_cnt_d = stall_cnt_q;
      if (stall_req && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < 32; i++) begin
            pend_q[i] <= '0;
         end
         long_busy_q  <= 1'b0;
         long_waddr_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         pend_q       <= pend_d;
         long_busy_q  <= long_busy_d;
         long_waddr_q <= long_waddr_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign sb.stall_req    = stall_req;
   assign sb.stall_reason = stall_reason;
   assign sb.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_scoreboard_hazard.sv
// -----------------------------------------------------------------------------
// tb_scoreboard_hazard
// Directed bench for scoreboard_hazard. Each step drives one decode cycle and
// queues the stall outputs that cycle must show; they are popped and compared
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_scoreboard_hazard;

   typedef struct {
      string       tag;
      logic        req;
      logic [1:0]  rsn;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;

   scoreboard_hazard_if sb_if ();

   scoreboard_hazard dut (
      .clk    (clk),
      .resetn (resetn),
      .sb     (sb_if)
   );

   always #5 clk = ~clk;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [15:0] model_cnt = '0;
   exp_t        exp_q[$];

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic set_in(input logic v, input logic we, input logic [4:0] wa,
                         input logic [1:0] lat, input logic [4:0] rs, input logic rse,
                         input logic [4:0] rt, input logic rte, input logic dd,
                         input logic hold, input logic fl);
      sb_if.id_valid   = v;
      sb_if.id_we      = we;
      sb_if.id_waddr   = wa;
      sb_if.id_lat     = lat;
      sb_if.rs_raddr   = rs;
      sb_if.rs_re      = rse;
      sb_if.rt_raddr   = rt;
      sb_if.rt_re      = rte;
      sb_if.div_done   = dd;
      sb_if.stall_hold = hold;
      sb_if.flush      = fl;
   endtask

   // one decode cycle: drive, queue expectation, compare at negedge, advance
   task automatic drive(input string tag, input logic v, input logic we, input logic [4:0] wa,
                        input logic [1:0] lat, input logic [4:0] rs, input logic rse,
                        input logic [4:0] rt, input logic rte, input logic dd,
                        input logic hold, input logic fl,
                        input logic ereq, input logic [1:0] ersn);
      exp_t e;
      set_in(v, we, wa, lat, rs, rse, rt, rte, dd, hold, fl);
      exp_q.push_back('{tag, ereq, ersn, model_cnt});
      if (ereq && (model_cnt != 16'hFFFF)) model_cnt = model_cnt + 16'd1;
      @(negedge clk);
      e = exp_q.pop_front();
      check({e.tag, ".req"}, {15'd0, sb_if.stall_req}, {15'd0, e.req});
      check({e.tag, ".rsn"}, {14'd0, sb_if.stall_reason}, {14'd0, e.rsn});
      check({e.tag, ".cnt"}, sb_if.stall_cnt, e.cnt);
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".req"}, {15'd0, sb_if.stall_req}, 16'd0);
      check({tag, ".rsn"}, {14'd0, sb_if.stall_reason}, 16'd0);
      check({tag, ".cnt"}, sb_if.stall_cnt, 16'd0);
   endtask

   // assert reset mid-cycle with current inputs held, then release after an edge
   task automatic mid_reset(input string tag);
      #2;
      resetn = 1'b0;
      #1;
      check_zero(tag);
      @(posedge clk);
      #1;
      resetn    = 1'b1;
      model_cnt = '0;
   endtask

   initial begin
      resetn = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check_zero("reset");
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // load-use: two stall cycles, issue on the third
      drive("ld5",      1, 1, 5, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("use5_s1",  1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 0, 0, 1, 2'b01);
      drive("use5_s2",  1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 0, 0, 1, 2'b01);
      drive("use5_go",  1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 0, 0, 0, 2'b00);
      // class 11 behaves as a load, rt path
      drive("ld6_11",   1, 1, 6, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("use6_s1",  1, 0, 0, 2'b00, 0, 0, 6, 1, 0, 0, 0, 1, 2'b01);
      drive("use6_s2",  1, 0, 0, 2'b00, 0, 0, 6, 1, 0, 0, 0, 1, 2'b01);
      drive("use6_go",  1, 0, 0, 2'b00, 0, 0, 6, 1, 0, 0, 0, 0, 2'b00);
      // unread sources and invalid decode never stall; countdown continues
      drive("ld6b",     1, 1, 6, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("noread6",  1, 0, 0, 2'b00, 6, 0, 6, 0, 0, 0, 0, 0, 2'b00);
      drive("read6",    1, 0, 0, 2'b00, 6, 1, 0, 0, 0, 0, 0, 1, 2'b01);
      drive("read6_go", 1, 0, 0, 2'b00, 6, 1, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("ld6c",     1, 1, 6, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("inval6",   0, 0, 0, 2'b00, 6, 1, 6, 1, 0, 0, 0, 0, 2'b00);
      drive("read6c",   1, 0, 0, 2'b00, 6, 1, 0, 0, 0, 0, 0, 1, 2'b01);
      drive("read6c_go",1, 0, 0, 2'b00, 6, 1, 0, 0, 0, 0, 0, 0, 2'b00);

      // WAW by ALU clears the load countdown
      drive("ld5w",     1, 1, 5, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("alu5",     1, 1, 5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("use5w",    1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 0, 0, 0, 2'b00);

      // external hold freezes the countdown
      drive("ld7",      1, 1, 7, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("hold7_1",  1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 1, 0, 1, 2'b01);
      drive("hold7_2",  1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 1, 0, 1, 2'b01);
      drive("hold7_3",  1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 1, 0, 1, 2'b01);
      drive("rel7_1",   1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 0, 0, 1, 2'b01);
      drive("rel7_2",   1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 0, 0, 1, 2'b01);
      drive("rel7_go",  1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 0, 0, 0, 2'b00);

      // long op data hazard, div_done bypass, structural, WAW, priorities
      drive("div9",     1, 1, 9, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("use9_s1",  1, 0, 0, 2'b00, 0, 0, 9, 1, 0, 0, 0, 1, 2'b10);
      drive("use9_s2",  1, 0, 0, 2'b00, 0, 0, 9, 1, 0, 0, 0, 1, 2'b10);
      drive("use9_dd",  1, 0, 0, 2'b00, 0, 0, 9, 1, 1, 0, 0, 0, 2'b00);
      drive("use9_aft", 1, 0, 0, 2'b00, 0, 0, 9, 1, 0, 0, 0, 0, 2'b00);
      drive("div10",    1, 1,10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("div11_st", 1, 1,11, 2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11);
      drive("waw10",    1, 1,10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10);
      drive("divrd10",  1, 1,11, 2'b10,10, 1, 0, 0, 0, 0, 0, 1, 2'b10);
      drive("div11_dd", 1, 1,11, 2'b10, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
      drive("use11",    1, 0, 0, 2'b00,11, 1, 0, 0, 0, 0, 0, 1, 2'b10);
      drive("ld4",      1, 1, 4, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("pri_s1",   1, 0, 0, 2'b00, 4, 1,11, 1, 0, 0, 0, 1, 2'b01);
      drive("pri_s2",   1, 0, 0, 2'b00, 4, 1,11, 1, 0, 0, 0, 1, 2'b01);
      drive("pri_s3",   1, 0, 0, 2'b00, 4, 1,11, 1, 0, 0, 0, 1, 2'b10);
      drive("pri_dd",   1, 0, 0, 2'b00, 4, 1,11, 1, 1, 0, 0, 0, 2'b00);
      drive("dd_idle",  1, 0, 0, 2'b00,11, 1, 0, 0, 1, 0, 0, 0, 2'b00);

      // flush clears tracking and overrides a same-cycle issue
      drive("ld3",      1, 1, 3, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("flush",    0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
      drive("use3",     1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("ld3_fl",   1, 1, 3, 2'b01, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
      drive("use3b",    1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("div12",    1, 1,12, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("flush2",   0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
      drive("div13",    1, 1,13, 2'b10,12, 1, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("dd13",     0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00);

      // register 0 never hazards; div to $0 still occupies the unit
      drive("ld0",      1, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("ld5z",     1, 1, 5, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("rd0",      1, 0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00);
      drive("div0",     1, 1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("rd0_div",  1, 1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00);
      drive("div14_st", 1, 1,14, 2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11);
      drive("dd0",      0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00);

      // reset mid countdown and mid long op
      drive("div15",    1, 1,15, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("ld5r",     1, 1, 5, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      drive("rd5r",     1, 0, 0, 2'b00, 5, 1,15, 1, 0, 0, 0, 1, 2'b01);
      mid_reset("midrst");
      drive("post_rst", 1, 1,15, 2'b10, 5, 1,15, 1, 0, 0, 0, 0, 2'b00);

      // saturation of the stall counter under a held hazard
      drive("sat_ld",   1, 1, 5, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
      set_in(1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 1, 0);
      repeat (70000) @(posedge clk);
      #1;
      model_cnt = 16'hFFFF;
      check("sat.cnt", sb_if.stall_cnt, 16'hFFFF);
      drive("sat_hold1",1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 1, 0, 1, 2'b01);
      drive("sat_hold2",1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 1, 0, 1, 2'b01);
      mid_reset("satrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
